// File: rtl/hermes_local_injector.sv
// Packet-locked round-robin arbiter that shares one Hermes router LOCAL port among NREQ sources.
// Optional macro HERMES_INJ_PRIO_EN makes requester 0 win every arbitration it takes part in.
module hermes_local_injector #(
    parameter int NREQ      = 4,
    parameter int FLIT_SIZE = 32,
    localparam int GW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NREQ-1:0]                     rx_i,
    input  logic [NREQ-1:0][FLIT_SIZE-1:0]      data_i,
    output logic [NREQ-1:0]                     credit_o,
    output logic                                rx_o,
    output logic [FLIT_SIZE-1:0]                data_o,
    input  logic                                credit_i,
    output logic [GW-1:0]                       grant_o,
    output logic                                busy_o
);

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        HEADER,
        SIZE,
        PAYLOAD
    } state_t;

    state_t               state;
    logic [GW-1:0]        ptr;
    logic [FLIT_SIZE-1:0] cnt;

    logic                 in_packet;
    logic                 sel_rx;
    logic [FLIT_SIZE-1:0] sel_data;
    logic                 xfer;
    logic                 rr_found;
    logic [GW-1:0]        rr_idx;
    logic                 prio_hit;

    assign in_packet = (state == HEADER) || (state == SIZE) || (state == PAYLOAD);
    assign sel_rx    = rx_i[grant_o];
    assign sel_data  = data_i[grant_o];
    assign rx_o      = in_packet & sel_rx;
    assign data_o    = in_packet ? sel_data : '0;
    assign xfer      = rx_o & credit_i;

    always_comb begin
        credit_o = '0;
        if (in_packet) begin
            credit_o[grant_o] = credit_i;
        end
    end

    // Search starts just above the pointer, so the last round-robin winner is checked last.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = ptr;
        for (int k = 1; k <= NREQ; k++) begin
            int cand;
            cand = (int'(ptr) + k) % NREQ;
            if (!rr_found && rx_i[cand]) begin
                rr_found = 1'b1;
                rr_idx   = GW'(cand);
            end
        end
    end

`ifdef HERMES_INJ_PRIO_EN
    assign prio_hit = rx_i[0];
`else
    assign prio_hit = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state   <= IDLE;
            grant_o <= '0;
            ptr     <= GW'(NREQ - 1);
            cnt     <= '0;
            busy_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|rx_i) begin
                        state <= ARB;
                    end
                end
                ARB: begin
                    // Priority grants leave the pointer alone so round-robin order resumes afterwards.
                    if (prio_hit) begin
                        grant_o <= '0;
                        state   <= HEADER;
                        busy_o  <= 1'b1;
                    end else if (rr_found) begin
                        grant_o <= rr_idx;
                        ptr     <= rr_idx;
                        state   <= HEADER;
                        busy_o  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                HEADER: begin
                    if (xfer) begin
                        state <= SIZE;
                    end
                end
                SIZE: begin
                    if (xfer) begin
                        cnt <= sel_data;
                        if (sel_data == '0) begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                        end else begin
                            state <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (xfer) begin
                        if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end
                        if (cnt <= FLIT_SIZE'(1)) begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
